// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station; optional oldest-first dispatch under RS_AGE_PRIO_EN

`ifndef ROB_POS_WID
// ROB tag width normally comes from cons.v; fall back to 4 bits when built standalone
`define ROB_POS_WID 4
`endif

module alu_rs #(
   parameter int RS_SIZE = 8,
   parameter int TAG_W   = `ROB_POS_WID
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rollback,
   input  logic              issue,
   input  logic [TAG_W-1:0]  issue_rob_pos,
   input  logic [6:0]        issue_opcode,
   input  logic [2:0]        issue_func3,
   input  logic              issue_func7,
   input  logic [31:0]       issue_rs1_val,
   input  logic [31:0]       issue_rs2_val,
   input  logic              issue_rs1_pend,
   input  logic              issue_rs2_pend,
   input  logic [TAG_W-1:0]  issue_rs1_tag,
   input  logic [TAG_W-1:0]  issue_rs2_tag,
   input  logic [31:0]       issue_imm,
   input  logic [31:0]       issue_pc,
   input  logic              alu_cdb,
   input  logic [TAG_W-1:0]  alu_cdb_rob_pos,
   input  logic [31:0]       alu_cdb_val,
   input  logic              lsb_cdb,
   input  logic [TAG_W-1:0]  lsb_cdb_rob_pos,
   input  logic [31:0]       lsb_cdb_val,
   output logic              full,
   output logic              alu_en,
   output logic [6:0]        opcode,
   output logic [2:0]        func3,
   output logic              func7,
   output logic [31:0]       val1,
   output logic [31:0]       val2,
   output logic [31:0]       imm,
   output logic [31:0]       pc,
   output logic [TAG_W-1:0]  rob_pos
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int CNT_W = $clog2(RS_SIZE + 1);

   // per-entry state
   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [RS_SIZE-1:0] pend1_q, pend1_d;
   logic [RS_SIZE-1:0] pend2_q, pend2_d;
   logic [RS_SIZE-1:0] f7_q, f7_d;
   logic [6:0]         opc_q  [RS_SIZE];
   logic [6:0]         opc_d  [RS_SIZE];
   logic [2:0]         f3_q   [RS_SIZE];
   logic [2:0]         f3_d   [RS_SIZE];
   logic [31:0]        v1_q   [RS_SIZE];
   logic [31:0]        v1_d   [RS_SIZE];
   logic [31:0]        v2_q   [RS_SIZE];
   logic [31:0]        v2_d   [RS_SIZE];
   logic [TAG_W-1:0]   t1_q   [RS_SIZE];
   logic [TAG_W-1:0]   t1_d   [RS_SIZE];
   logic [TAG_W-1:0]   t2_q   [RS_SIZE];
   logic [TAG_W-1:0]   t2_d   [RS_SIZE];
   logic [31:0]        imm_q  [RS_SIZE];
   logic [31:0]        imm_d  [RS_SIZE];
   logic [31:0]        pc_q   [RS_SIZE];
   logic [31:0]        pc_d   [RS_SIZE];
   logic [TAG_W-1:0]   rob_q  [RS_SIZE];
   logic [TAG_W-1:0]   rob_d  [RS_SIZE];

   // dispatch output registers
   logic               alu_en_q, full_q, full_d, f7o_q;
   logic [6:0]         opco_q;
   logic [2:0]         f3o_q;
   logic [31:0]        v1o_q, v2o_q, immo_q, pco_q;
   logic [TAG_W-1:0]   robo_q;

   // allocation / selection
   logic [RS_SIZE-1:0] ready;
   logic               sel_vld, free_vld, do_alloc;
   logic [IDX_W-1:0]   sel_idx, free_idx;
   logic [CNT_W-1:0]   busy_cnt;

`ifdef RS_AGE_PRIO_EN
   // age_q[i][j] set: entry i was allocated before entry j
   logic [RS_SIZE-1:0] age_q [RS_SIZE];
   logic [RS_SIZE-1:0] age_d [RS_SIZE];
`endif

   // operand wakeup against both CDBs; ALU CDB wins when both carry the same tag
   function automatic logic [32:0] wake(input logic pend, input logic [TAG_W-1:0] tag,
                                        input logic [31:0] val);
      logic [32:0] r;
      r = {pend, val};
      if (pend) begin
         if (alu_cdb && alu_cdb_rob_pos == tag)
            r = {1'b0, alu_cdb_val};
         else if (lsb_cdb && lsb_cdb_rob_pos == tag)
            r = {1'b0, lsb_cdb_val};
      end
      return r;
   endfunction

   // pick the entry to dispatch from registered state and the lowest free slot
   always_comb begin
      ready    = busy_q & ~pend1_q & ~pend2_q;
      sel_vld  = |ready;
      sel_idx  = '0;
      free_vld = ~&busy_q;
      free_idx = '0;
`ifdef RS_AGE_PRIO_EN
      for (int i = 0; i < RS_SIZE; i++) begin
         logic oldest;
         oldest = ready[i];
         for (int j = 0; j < RS_SIZE; j++) begin
            if (j != i && ready[j] && !age_q[i][j])
               oldest = 1'b0;
         end
         if (oldest)
            sel_idx = IDX_W'(i);
      end
`else
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (ready[i])
            sel_idx = IDX_W'(i);
      end
`endif
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i])
            free_idx = IDX_W'(i);
      end
   end

   assign do_alloc = rdy && issue && free_vld;

   // next-state of every entry: CDB capture, dispatch release, new allocation
   always_comb begin
      busy_d  = busy_q;
      pend1_d = pend1_q;
      pend2_d = pend2_q;
      f7_d    = f7_q;
      opc_d   = opc_q;
      f3_d    = f3_q;
      v1_d    = v1_q;
      v2_d    = v2_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      rob_d   = rob_q;
      if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               {pend1_d[i], v1_d[i]} = wake(pend1_q[i], t1_q[i], v1_q[i]);
               {pend2_d[i], v2_d[i]} = wake(pend2_q[i], t2_q[i], v2_q[i]);
            end
         end
         if (sel_vld)
            busy_d[sel_idx] = 1'b0;
         if (do_alloc) begin
            busy_d[free_idx] = 1'b1;
            opc_d[free_idx]  = issue_opcode;
            f3_d[free_idx]   = issue_func3;
            f7_d[free_idx]   = issue_func7;
            t1_d[free_idx]   = issue_rs1_tag;
            t2_d[free_idx]   = issue_rs2_tag;
            imm_d[free_idx]  = issue_imm;
            pc_d[free_idx]   = issue_pc;
            rob_d[free_idx]  = issue_rob_pos;
            {pend1_d[free_idx], v1_d[free_idx]} = wake(issue_rs1_pend, issue_rs1_tag, issue_rs1_val);
            {pend2_d[free_idx], v2_d[free_idx]} = wake(issue_rs2_pend, issue_rs2_tag, issue_rs2_val);
         end
      end
      busy_cnt = '0;
      for (int i = 0; i < RS_SIZE; i++)
         busy_cnt = busy_cnt + CNT_W'(busy_d[i]);
      // raise full one entry early so an issue already in flight still has a slot
      full_d = (busy_cnt >= CNT_W'(RS_SIZE - 1));
   end

`ifdef RS_AGE_PRIO_EN
   // a new entry becomes younger than every currently busy entry
   always_comb begin
      age_d = age_q;
      if (do_alloc) begin
         for (int j = 0; j < RS_SIZE; j++) begin
            age_d[free_idx][j] = 1'b0;
            if (IDX_W'(j) != free_idx)
               age_d[j][free_idx] = busy_q[j];
         end
      end
   end

   // age matrix register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_SIZE; i++)
            age_q[i] <= '0;
      end else if (!rollback) begin
         age_q <= age_d;
      end
   end
`endif

   // occupancy register; reset and rollback override everything else
   always_ff @(posedge clk) begin
      if (rst || rollback)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   // entry payload register; meaningless while the entry is not busy
   always_ff @(posedge clk) begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      f7_q    <= f7_d;
      opc_q   <= opc_d;
      f3_q    <= f3_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rob_q   <= rob_d;
   end

   // dispatch registers; fields hold when nothing is selected or rdy is low
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_en_q <= 1'b0;
         full_q   <= 1'b0;
         opco_q   <= '0;
         f3o_q    <= '0;
         f7o_q    <= 1'b0;
         v1o_q    <= '0;
         v2o_q    <= '0;
         immo_q   <= '0;
         pco_q    <= '0;
         robo_q   <= '0;
      end else if (rollback) begin
         alu_en_q <= 1'b0;
         full_q   <= 1'b0;
      end else if (rdy) begin
         alu_en_q <= sel_vld;
         full_q   <= full_d;
         if (sel_vld) begin
            opco_q <= opc_q[sel_idx];
            f3o_q  <= f3_q[sel_idx];
            f7o_q  <= f7_q[sel_idx];
            v1o_q  <= v1_q[sel_idx];
            v2o_q  <= v2_q[sel_idx];
            immo_q <= imm_q[sel_idx];
            pco_q  <= pc_q[sel_idx];
            robo_q <= rob_q[sel_idx];
         end
      end
   end

   assign full    = full_q;
   assign alu_en  = alu_en_q;
   assign opcode  = opco_q;
   assign func3   = f3o_q;
   assign func7   = f7o_q;
   assign val1    = v1o_q;
   assign val2    = v2o_q;
   assign imm     = immo_q;
   assign pc      = pco_q;
   assign rob_pos = robo_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - directed self-checking bench for alu_rs

module tb_alu_rs;

   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, issue;
   logic [3:0]  issue_rob_pos, issue_rs1_tag, issue_rs2_tag;
   logic [6:0]  issue_opcode;
   logic [2:0]  issue_func3;
   logic        issue_func7, issue_rs1_pend, issue_rs2_pend;
   logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   logic        alu_cdb, lsb_cdb;
   logic [3:0]  alu_cdb_rob_pos, lsb_cdb_rob_pos;
   logic [31:0] alu_cdb_val, lsb_cdb_val;
   logic        full, alu_en, func7;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [31:0] val1, val2, imm, pc;
   logic [3:0]  rob_pos;

   int n_checks = 0;
   int n_pass   = 0;

   alu_rs #(.RS_SIZE(8), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .issue(issue),
      .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
      .issue_func3(issue_func3), .issue_func7(issue_func7),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_pend(issue_rs1_pend), .issue_rs2_pend(issue_rs2_pend),
      .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
      .issue_imm(issue_imm), .issue_pc(issue_pc),
      .alu_cdb(alu_cdb), .alu_cdb_rob_pos(alu_cdb_rob_pos), .alu_cdb_val(alu_cdb_val),
      .lsb_cdb(lsb_cdb), .lsb_cdb_rob_pos(lsb_cdb_rob_pos), .lsb_cdb_val(lsb_cdb_val),
      .full(full), .alu_en(alu_en), .opcode(opcode), .func3(func3), .func7(func7),
      .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // advance one edge; inputs are driven and outputs sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_one(input logic [3:0] rob, input logic [6:0] opc,
                            input logic [31:0] v1, input logic p1, input logic [3:0] t1,
                            input logic [31:0] v2, input logic p2, input logic [3:0] t2,
                            input logic [31:0] im);
      issue = 1'b1; issue_rob_pos = rob; issue_opcode = opc;
      issue_func3 = 3'd0; issue_func7 = 1'b0;
      issue_rs1_val = v1; issue_rs1_pend = p1; issue_rs1_tag = t1;
      issue_rs2_val = v2; issue_rs2_pend = p2; issue_rs2_tag = t2;
      issue_imm = im; issue_pc = 32'h100 + {28'd0, rob};
      tick();
      issue = 1'b0;
   endtask

   task automatic cdb(input logic a, input logic [3:0] at, input logic [31:0] av,
                      input logic l, input logic [3:0] lt, input logic [31:0] lv);
      alu_cdb = a; alu_cdb_rob_pos = at; alu_cdb_val = av;
      lsb_cdb = l; lsb_cdb_rob_pos = lt; lsb_cdb_val = lv;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0;
      issue_rob_pos = '0; issue_opcode = '0; issue_func3 = '0; issue_func7 = 1'b0;
      issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_pend = 1'b0; issue_rs2_pend = 1'b0;
      issue_rs1_tag = '0; issue_rs2_tag = '0; issue_imm = '0; issue_pc = '0;
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_alu_en", {31'd0, alu_en}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_val1", val1, 32'd0);
      check("rst_rob_pos", {28'd0, rob_pos}, 32'd0);
      check("rst_opcode", {25'd0, opcode}, 32'd0);

      // ADDI rob 3, rs1=5, imm 7: dispatch one edge after the issue edge
      issue_one(4'd3, OP_ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7);
      check("addi_not_yet", {31'd0, alu_en}, 32'd0);
      tick();
      check("addi_alu_en", {31'd0, alu_en}, 32'd1);
      check("addi_val1", val1, 32'd5);
      check("addi_imm", imm, 32'd7);
      check("addi_rob", {28'd0, rob_pos}, 32'd3);
      check("addi_opcode", {25'd0, opcode}, {25'd0, OP_ADDI});
      check("addi_pc", pc, 32'h103);
      tick();
      check("addi_freed", {31'd0, alu_en}, 32'd0);
      check("hold_val1", val1, 32'd5);

      // ADD rob 4, rs1 pending on tag 2, woken later by the ALU CDB
      issue_one(4'd4, OP_ADD, 32'd0, 1'b1, 4'd2, 32'd3, 1'b0, 4'd0, 32'd0);
      tick();
      check("add_wait", {31'd0, alu_en}, 32'd0);
      cdb(1'b1, 4'd2, 32'h10, 1'b0, 4'd0, 32'd0);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      check("add_wake_edge", {31'd0, alu_en}, 32'd0);
      tick();
      check("add_alu_en", {31'd0, alu_en}, 32'd1);
      check("add_val1", val1, 32'h10);
      check("add_val2", val2, 32'd3);
      check("add_rob", {28'd0, rob_pos}, 32'd4);
      tick();

      // issue-cycle wakeup from the LSB CDB
      cdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hAB);
      issue_one(4'd5, OP_ADD, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'd0);
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      check("isw_alu_en", {31'd0, alu_en}, 32'd1);
      check("isw_val2", val2, 32'hAB);
      check("isw_rob", {28'd0, rob_pos}, 32'd5);
      tick();

      // both CDBs on the same tag: ALU value wins
      issue_one(4'd7, OP_ADD, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0);
      cdb(1'b1, 4'd9, 32'h11, 1'b1, 4'd9, 32'h22);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      check("dual_cdb_val1", val1, 32'h11);
      check("dual_cdb_rob", {28'd0, rob_pos}, 32'd7);
      tick();

      // rdy low: issue ignored and dispatch outputs held
      issue_one(4'd9, OP_ADDI, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1);
      tick();
      check("pre_hold_en", {31'd0, alu_en}, 32'd1);
      rdy = 1'b0;
      tick();
      check("rdy0_hold_en", {31'd0, alu_en}, 32'd1);
      issue_one(4'd10, OP_ADDI, 32'd10, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      rdy = 1'b1;
      tick();
      check("rdy0_issue_lost", {31'd0, alu_en}, 32'd0);
      tick();
      check("rdy0_issue_lost2", {31'd0, alu_en}, 32'd0);

      // fill all 8 entries pending on tag 10
      for (int i = 0; i < 8; i++) begin
         issue_one(4'(i), OP_ADD, 32'd0, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0);
         if (i == 5) check("full_at_6", {31'd0, full}, 32'd0);
         if (i == 6) check("full_at_7", {31'd0, full}, 32'd1);
         if (i == 7) check("full_at_8", {31'd0, full}, 32'd1);
      end
      issue_one(4'd15, OP_ADDI, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      check("extra_issue_a", {31'd0, alu_en}, 32'd0);
      tick();
      check("extra_issue_b", {31'd0, alu_en}, 32'd0);

      // wake all, then roll back while a dispatch is on the outputs
      cdb(1'b1, 4'd10, 32'h55, 1'b0, 4'd0, 32'd0);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      check("pre_rb_alu_en", {31'd0, alu_en}, 32'd1);
      check("pre_rb_rob", {28'd0, rob_pos}, 32'd0);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("rb_alu_en", {31'd0, alu_en}, 32'd0);
      check("rb_full", {31'd0, full}, 32'd0);
      cdb(1'b1, 4'd10, 32'h66, 1'b0, 4'd0, 32'd0);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      check("rb_no_dispatch_a", {31'd0, alu_en}, 32'd0);
      tick();
      check("rb_no_dispatch_b", {31'd0, alu_en}, 32'd0);

      // make entry 5 older than entry 1, then wake both together
      issue_one(4'd0, OP_ADD, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      issue_one(4'd1, OP_ADD, 32'd0, 1'b1, 4'd1,  32'd0, 1'b0, 4'd0, 32'd0);
      issue_one(4'd2, OP_ADD, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      issue_one(4'd3, OP_ADD, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      issue_one(4'd4, OP_ADD, 32'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
      issue_one(4'd5, OP_ADD, 32'd0, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0);
      cdb(1'b1, 4'd1, 32'h1, 1'b0, 4'd0, 32'd0);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      check("free_e1_rob", {28'd0, rob_pos}, 32'd1);
      issue_one(4'd8, OP_ADD, 32'd0, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0);
      cdb(1'b1, 4'd14, 32'h14, 1'b1, 4'd13, 32'h13);
      tick();
      cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
`ifdef RS_AGE_PRIO_EN
      check("prio_first_rob", {28'd0, rob_pos}, 32'd5);
      check("prio_first_val", val1, 32'h13);
      tick();
      check("prio_second_rob", {28'd0, rob_pos}, 32'd8);
      check("prio_second_val", val1, 32'h14);
`else
      check("prio_first_rob", {28'd0, rob_pos}, 32'd8);
      check("prio_first_val", val1, 32'h14);
      tick();
      check("prio_second_rob", {28'd0, rob_pos}, 32'd5);
      check("prio_second_val", val1, 32'h13);
`endif
      check("prio_second_en", {31'd0, alu_en}, 32'd1);
      tick();
      check("prio_drained", {31'd0, alu_en}, 32'd0);

      // reset after activity clears the dispatch fields
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_val1", val1, 32'd0);
      check("rst2_rob", {28'd0, rob_pos}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
